// File: rtl/game_pkg.sv
// Command codes and button indices shared by the input front end and the 2048 board engine.
package game_pkg;

    localparam int unsigned CMD_W = 3;
    localparam int unsigned BTN_W = 5;
    localparam int unsigned REP_W = 8;

    localparam logic [CMD_W-1:0] CMD_NONE     = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP       = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN     = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT     = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT    = 3'd4;
    localparam logic [CMD_W-1:0] CMD_NEW_GAME = 3'd5;

    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_START = 4;

    typedef logic [BTN_W-1:0] btn_t;

    // Highest-priority new press wins: start > up > down > left > right.
    function automatic logic [CMD_W-1:0] pick_cmd(input btn_t rise);
        logic [CMD_W-1:0] cmd;
        cmd = CMD_NONE;
        if (rise[BTN_START]) begin
            cmd = CMD_NEW_GAME;
        end else if (rise[BTN_UP]) begin
            cmd = CMD_UP;
        end else if (rise[BTN_DOWN]) begin
            cmd = CMD_DOWN;
        end else if (rise[BTN_LEFT]) begin
            cmd = CMD_LEFT;
        end else if (rise[BTN_RIGHT]) begin
            cmd = CMD_RIGHT;
        end
        return cmd;
    endfunction

    function automatic logic dir_held(input logic [CMD_W-1:0] dir, input btn_t btn);
        logic held;
        held = 1'b0;
        case (dir)
            CMD_UP:    held = btn[BTN_UP];
            CMD_DOWN:  held = btn[BTN_DOWN];
            CMD_LEFT:  held = btn[BTN_LEFT];
            CMD_RIGHT: held = btn[BTN_RIGHT];
            default:   held = 1'b0;
        endcase
        return held;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command queue with a registered head and a registered overflow pulse.
module cmd_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             overflow_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic full_c, empty_c, do_push_c, do_pop_c;

    assign empty_c   = (count_q == '0);
    assign full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop_c  = pop_i && !empty_c;
    // A pop on the same edge frees the slot, so a push into a full queue still lands.
    assign do_push_c = push_i && (!full_c || do_pop_c);

    always_comb begin
        wr_d    = wr_q + PW'(do_push_c);
        rd_d    = rd_q + PW'(do_pop_c);
        count_d = count_q + PW'(do_push_c) - PW'(do_pop_c);
        ovf_d   = push_i && full_c && !do_pop_c;
        valid_d = (count_d != '0);
        head_d  = '0;
        // Next head is either the entry being written this edge or one already stored.
        if (count_d != '0) begin
            if (do_push_c && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/move_cmd_queue.sv
// Per-frame button sampling, press detection, priority pick and auto-repeat feeding a command queue.
module move_cmd_queue
    import game_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned REPEAT_FRAMES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       is_present,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       overflow
);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
    localparam bit               REP_EN   = (REPEAT_FRAMES != 0);

    btn_t             btn_c, rise_c;
    btn_t             btn_prev_q, btn_prev_d;
    logic [CMD_W-1:0] rep_dir_q, rep_dir_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CMD_W-1:0] sel_c;
    logic             push_c;
    logic [CMD_W-1:0] push_code_c;

    // A disconnected controller reads as all buttons released.
    assign btn_c  = {start, up, down, left, right} & {BTN_W{is_present}};
    assign rise_c = btn_c & ~btn_prev_q;
    assign sel_c  = pick_cmd(rise_c);

    always_comb begin
        btn_prev_d  = btn_prev_q;
        rep_dir_d   = rep_dir_q;
        rep_cnt_d   = rep_cnt_q;
        push_c      = 1'b0;
        push_code_c = CMD_NONE;
        if (frame_tick) begin
            btn_prev_d = btn_c;
            if (rise_c != '0) begin
                push_c      = 1'b1;
                push_code_c = sel_c;
                rep_dir_d   = (sel_c == CMD_NEW_GAME) ? CMD_NONE : sel_c;
                rep_cnt_d   = '0;
            end else if (rep_dir_q != CMD_NONE) begin
                if (!dir_held(rep_dir_q, btn_c)) begin
                    rep_dir_d = CMD_NONE;
                    rep_cnt_d = '0;
                end else if (REP_EN) begin
                    if (rep_cnt_q == REP_LAST) begin
                        push_c      = 1'b1;
                        push_code_c = rep_dir_q;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            rep_dir_q  <= CMD_NONE;
            rep_cnt_q  <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            rep_dir_q  <= rep_dir_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .push_data_i (push_code_c),
        .pop_i       (cmd_ready),
        .valid_o     (cmd_valid),
        .head_o      (cmd_code),
        .overflow_o  (overflow)
    );

endmodule
